// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN feature-map buffering blocks.
package cnn_pkg;

   typedef enum logic {
      S_FILL  = 1'b0,
      S_DRAIN = 1'b1
   } fmap_state_t;

   // A depth of one still needs a one-bit pointer so ports never collapse to zero width.
   function automatic int fmap_ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fmap_bank_ram.sv
// One-write / one-read frame bank with a registered read port; the read register holds
// its value between reads and is cleared by reset while the array itself is not.
module fmap_bank_ram
   import cnn_pkg::*;
#(
   parameter int pWIDTH = 8,
   parameter int pDEPTH = 16
)(
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              we_i,
   input  logic [fmap_ptr_width(pDEPTH)-1:0] waddr_i,
   input  logic [pWIDTH-1:0]                 wdata_i,
   input  logic                              re_i,
   input  logic [fmap_ptr_width(pDEPTH)-1:0] raddr_i,
   output logic [pWIDTH-1:0]                 rdata_o
);

   logic [pWIDTH-1:0] mem_q [pDEPTH];
   logic [pWIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap_stream_buffer.sv
// Feature-map frame buffer between two conv layers: captures a full frame, then serves it
// with one-cycle rd_en -> data_valid latency. FMAP_STREAM_BUFFER_PINGPONG_EN selects two banks.
module fmap_stream_buffer
   import cnn_pkg::*;
#(
   parameter int pDATA_WIDTH   = 8,
   parameter int pCHANNEL      = 32,
   parameter int pINPUT_WIDTH  = 28,
   parameter int pINPUT_HEIGHT = 28
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wr_valid,
   input  logic [pDATA_WIDTH*pCHANNEL-1:0] wr_data,
   input  logic                            rd_en,
   output logic [pDATA_WIDTH*pCHANNEL-1:0] data_out,
   output logic                            data_valid,
   output logic                            frame_ready,
   output logic                            rd_done,
   output logic                            overflow
);

   localparam int pDEPTH = pINPUT_WIDTH * pINPUT_HEIGHT;
   localparam int PTR_W  = fmap_ptr_width(pDEPTH);
   localparam int DATA_W = pDATA_WIDTH * pCHANNEL;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(pDEPTH - 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic             rd_done_q, rd_done_d;
   logic             data_valid_q;
   logic             ram_we;
   logic             ram_re;

`ifdef FMAP_STREAM_BUFFER_PINGPONG_EN

   fmap_state_t bank_state_q [2];
   fmap_state_t bank_state_d [2];
   logic        wr_bank_q, wr_bank_d;
   logic        rd_bank_q, rd_bank_d;
   logic        rd_sel_q;
   logic [DATA_W-1:0] rdata0, rdata1;

   // Writes and reads are judged against the pre-edge bank states; they can never complete
   // the same bank in one cycle because a bank cannot be both FILL and DRAIN.
   always_comb begin
      bank_state_d = bank_state_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      overflow_d   = overflow_q;
      rd_done_d    = 1'b0;
      ram_we       = 1'b0;
      ram_re       = 1'b0;
      if (wr_valid) begin
         if (bank_state_q[wr_bank_q] == S_FILL) begin
            ram_we = 1'b1;
            if (wr_ptr_q == LAST_PTR) begin
               wr_ptr_d                = '0;
               bank_state_d[wr_bank_q] = S_DRAIN;
               wr_bank_d               = ~wr_bank_q;
            end else begin
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
         end else begin
            overflow_d = 1'b1;
         end
      end
      if (rd_en && (bank_state_q[rd_bank_q] == S_DRAIN)) begin
         ram_re = 1'b1;
         if (rd_ptr_q == LAST_PTR) begin
            rd_ptr_d                = '0;
            rd_done_d               = 1'b1;
            bank_state_d[rd_bank_q] = S_FILL;
            rd_bank_d               = ~rd_bank_q;
         end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // rd_sel_q remembers which bank the last read came from so data_out holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_state_q[0] <= S_FILL;
         bank_state_q[1] <= S_FILL;
         wr_bank_q       <= 1'b0;
         rd_bank_q       <= 1'b0;
         rd_sel_q        <= 1'b0;
      end else begin
         bank_state_q <= bank_state_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         if (ram_re) begin
            rd_sel_q <= rd_bank_q;
         end
      end
   end

   fmap_bank_ram #(.pWIDTH(DATA_W), .pDEPTH(pDEPTH)) u_bank0 (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (ram_we & ~wr_bank_q),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .re_i    (ram_re & ~rd_bank_q),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata0)
   );

   fmap_bank_ram #(.pWIDTH(DATA_W), .pDEPTH(pDEPTH)) u_bank1 (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (ram_we & wr_bank_q),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .re_i    (ram_re & rd_bank_q),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata1)
   );

   assign data_out    = rd_sel_q ? rdata1 : rdata0;
   assign frame_ready = (bank_state_q[0] == S_DRAIN) || (bank_state_q[1] == S_DRAIN);

`else

   fmap_state_t state_q, state_d;

   // In DRAIN every write is dropped, including one coinciding with the final read request.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      rd_done_d  = 1'b0;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
      case (state_q)
         S_FILL: begin
            if (wr_valid) begin
               ram_we = 1'b1;
               if (wr_ptr_q == LAST_PTR) begin
                  wr_ptr_d = '0;
                  state_d  = S_DRAIN;
               end else begin
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (wr_valid) begin
               overflow_d = 1'b1;
            end
            if (rd_en) begin
               ram_re = 1'b1;
               if (rd_ptr_q == LAST_PTR) begin
                  rd_ptr_d  = '0;
                  rd_done_d = 1'b1;
                  state_d   = S_FILL;
               end else begin
                  rd_ptr_d = rd_ptr_q + PTR_W'(1);
               end
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   fmap_bank_ram #(.pWIDTH(DATA_W), .pDEPTH(pDEPTH)) u_bank (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .re_i    (ram_re),
      .raddr_i (rd_ptr_q),
      .rdata_o (data_out)
   );

   assign frame_ready = (state_q == S_DRAIN);

`endif

   // data_valid and rd_done are registered alongside the RAM read so they line up with data_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         rd_done_q    <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         rd_done_q    <= rd_done_d;
         data_valid_q <= ram_re;
      end
   end

   assign data_valid = data_valid_q;
   assign rd_done    = rd_done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_fmap_stream_buffer.sv
// Self-checking bench for fmap_stream_buffer on a 4x4 frame of 32-bit pixel words, with a
// frame-queue reference model that covers both the single-bank and ping-pong builds.
module tb_fmap_stream_buffer;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 32;
`ifdef FMAP_STREAM_BUFFER_PINGPONG_EN
   localparam int NBANKS = 2;
`else
   localparam int NBANKS = 1;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              frame_ready;
   logic              rd_done;
   logic              overflow;

   fmap_stream_buffer #(
      .pDATA_WIDTH   (8),
      .pCHANNEL      (4),
      .pINPUT_WIDTH  (4),
      .pINPUT_HEIGHT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_ready (frame_ready),
      .rd_done     (rd_done),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: a partially captured frame plus a word queue of complete frames.
   logic [DATA_W-1:0] fillQ [$];
   logic [DATA_W-1:0] readyQ [$];
   int                mFrames;
   int                mReadIdx;
   logic              mValid;
   logic              mDone;
   logic              mOvf;
   logic [DATA_W-1:0] mData;

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct {
      logic              wv;
      logic [DATA_W-1:0] wd;
      logic              re;
      logic              expValid;
      logic [DATA_W-1:0] expData;
      logic              expReady;
      logic              expDone;
      logic              expOvf;
   } vec_t;

   vec_t vecs [33];

   task automatic modelStep(input logic wv, input logic [DATA_W-1:0] wd, input logic re, input logic rs);
      int  newFrames;
      logic canWrite;
      logic canRead;
      if (rs) begin
         fillQ.delete();
         readyQ.delete();
         mFrames  = 0;
         mReadIdx = 0;
         mValid   = 1'b0;
         mDone    = 1'b0;
         mOvf     = 1'b0;
         mData    = '0;
         return;
      end
      canWrite  = (mFrames < NBANKS);
      canRead   = (mFrames > 0);
      newFrames = mFrames;
      mValid    = 1'b0;
      mDone     = 1'b0;
      if (re && canRead) begin
         mData  = readyQ.pop_front();
         mValid = 1'b1;
         mReadIdx++;
         if (mReadIdx == DEPTH) begin
            mReadIdx = 0;
            mDone    = 1'b1;
            newFrames--;
         end
      end
      if (wv) begin
         if (canWrite) begin
            fillQ.push_back(wd);
            if (fillQ.size() == DEPTH) begin
               foreach (fillQ[k]) readyQ.push_back(fillQ[k]);
               fillQ.delete();
               newFrames++;
            end
         end else begin
            mOvf = 1'b1;
         end
      end
      mFrames = newFrames;
   endtask

   task automatic driveCycle(input logic wv, input logic [DATA_W-1:0] wd, input logic re, input logic rs);
      @(negedge clk);
      wr_valid = wv;
      wr_data  = wd;
      rd_en    = re;
      rst      = rs;
      @(posedge clk);
      modelStep(wv, wd, re, rs);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, ".valid"}, DATA_W'(data_valid),  DATA_W'(mValid));
      checkOutput({tag, ".data"},  data_out,             mData);
      checkOutput({tag, ".ready"}, DATA_W'(frame_ready), DATA_W'(mFrames > 0));
      checkOutput({tag, ".done"},  DATA_W'(rd_done),     DATA_W'(mDone));
      checkOutput({tag, ".ovf"},   DATA_W'(overflow),    DATA_W'(mOvf));
   endtask

   task automatic applyStimulus(input string tag, input logic wv, input logic [DATA_W-1:0] wd,
                                input logic re, input logic rs);
      driveCycle(wv, wd, re, rs);
      checkModel(tag);
   endtask

   initial begin
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_data  = '0;
      rd_en    = 1'b0;

      applyStimulus("reset", 1'b0, '0, 1'b0, 1'b1);
      applyStimulus("reset", 1'b1, 32'hdead_beef, 1'b1, 1'b1);
      checkOutput("resetData", data_out, '0);
      applyStimulus("idle", 1'b0, '0, 1'b0, 1'b0);

      // Directed fill of 0..15 followed by a back-to-back drain and one idle cycle.
      for (int i = 0; i < DEPTH; i++) begin
         vecs[i] = '{1'b1, DATA_W'(i), 1'b0, 1'b0, '0, (i == DEPTH - 1), 1'b0, 1'b0};
      end
      for (int j = 0; j < DEPTH; j++) begin
         vecs[DEPTH + j] = '{1'b0, '0, 1'b1, 1'b1, DATA_W'(j), (j != DEPTH - 1), (j == DEPTH - 1), 1'b0};
      end
      vecs[2 * DEPTH] = '{1'b0, '0, 1'b0, 1'b0, DATA_W'(DEPTH - 1), 1'b0, 1'b0, 1'b0};
      for (int v = 0; v < 33; v++) begin
         driveCycle(vecs[v].wv, vecs[v].wd, vecs[v].re, 1'b0);
         checkOutput($sformatf("vec%0d.valid", v), DATA_W'(data_valid),  DATA_W'(vecs[v].expValid));
         if (vecs[v].expValid || v == 32)
            checkOutput($sformatf("vec%0d.data", v), data_out, vecs[v].expData);
         checkOutput($sformatf("vec%0d.ready", v), DATA_W'(frame_ready), DATA_W'(vecs[v].expReady));
         checkOutput($sformatf("vec%0d.done", v),  DATA_W'(rd_done),     DATA_W'(vecs[v].expDone));
         checkOutput($sformatf("vec%0d.ovf", v),   DATA_W'(overflow),    DATA_W'(vecs[v].expOvf));
      end

      // rd_en held high throughout the fill must be ignored, then gapped reads every third cycle.
      for (int i = 0; i < DEPTH; i++) applyStimulus("fillRdHigh", 1'b1, $urandom, 1'b1, 1'b0);
      for (int i = 0; i < 3 * DEPTH + 3; i++) applyStimulus("gapped", 1'b0, '0, (i % 3 == 0), 1'b0);

`ifdef FMAP_STREAM_BUFFER_PINGPONG_EN
      // Frame A, then drain A while writing B, then drain B; finally fill both banks and overflow.
      for (int i = 0; i < DEPTH; i++) applyStimulus("ppFillA", 1'b1, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) applyStimulus("ppOverlap", 1'b1, $urandom, 1'b1, 1'b0);
      checkOutput("ppNoOvf", DATA_W'(overflow), '0);
      for (int i = 0; i < DEPTH + 1; i++) applyStimulus("ppDrainB", 1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 2 * DEPTH; i++) applyStimulus("ppFillCD", 1'b1, $urandom, 1'b0, 1'b0);
      checkOutput("ppFullNoOvf", DATA_W'(overflow), '0);
      applyStimulus("ppThird", 1'b1, $urandom, 1'b0, 1'b0);
      checkOutput("ppOvf", DATA_W'(overflow), 32'd1);
      for (int i = 0; i < 2 * DEPTH + 1; i++) applyStimulus("ppDrainCD", 1'b0, '0, 1'b1, 1'b0);
`else
      // Writes during the drain, including one on the final request, are dropped and flagged.
      for (int i = 0; i < DEPTH; i++) applyStimulus("ovfFill", 1'b1, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) applyStimulus("ovfDrain", 1'b1, $urandom, 1'b1, 1'b0);
      checkOutput("ovfSet", DATA_W'(overflow), 32'd1);
      for (int i = 0; i < 3; i++) applyStimulus("ovfSticky", 1'b0, '0, 1'b0, 1'b0);
      checkOutput("ovfHeld", DATA_W'(overflow), 32'd1);
`endif

      // Reset after 7 writes with a read pending, then a fresh frame drained in full.
      for (int i = 0; i < 7; i++) applyStimulus("preRst", 1'b1, $urandom, 1'b0, 1'b0);
      applyStimulus("midRst", 1'b1, $urandom, 1'b1, 1'b1);
      checkOutput("rstValid", DATA_W'(data_valid), '0);
      checkOutput("rstReady", DATA_W'(frame_ready), '0);
      checkOutput("rstOvf", DATA_W'(overflow), '0);
      checkOutput("rstData", data_out, '0);
      for (int i = 0; i < DEPTH; i++) applyStimulus("postRstFill", 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH + 1; i++) applyStimulus("postRstDrain", 1'b0, '0, 1'b1, 1'b0);

      // Randomised traffic with rare resets against the model.
      for (int i = 0; i < 600; i++) begin
         applyStimulus("rand", ($urandom % 3) != 0, $urandom, ($urandom % 2) == 0, ($urandom % 250) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
